// File: rtl/pipelined_rom.sv
// Pipelined synchronous ROM with valid/ready request and response ports.
// Path: accept -> fetch stage F -> optional retime stage G -> 2-entry response FIFO.
// The output shows the FIFO head, or the last pipeline stage directly when the FIFO is empty.
// An occupancy counter bounds the in-flight requests, so the FIFO never overflows.
// Build option: define ROM_OUT_REG_EN to add stage G. This raises latency to 2 and CAP to 3.
module pipelined_rom #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err
);

`ifdef ROM_OUT_REG_EN
  localparam int unsigned Cap = 3;
`else
  localparam int unsigned Cap = 2;
`endif
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Each entry is {err, data}.
  localparam int unsigned EntW = DATA_WIDTH + 1;

  function automatic logic [DATA_WIDTH-1:0] default_word(input int unsigned i);
    case (i)
      0:       default_word = DATA_WIDTH'(32'h1);
      1:       default_word = DATA_WIDTH'(32'h11);
      2:       default_word = DATA_WIDTH'(32'h11);
      3:       default_word = DATA_WIDTH'(32'hF);
      4:       default_word = DATA_WIDTH'(32'hC);
      5:       default_word = DATA_WIDTH'(32'hD001);
      default: default_word = '0;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign mem[i] = default_word(i);
  end

  logic                  f_valid_q, f_valid_d;
  logic [EntW-1:0]       f_ent_q, f_ent_d;
`ifdef ROM_OUT_REG_EN
  logic                  g_valid_q, g_valid_d;
  logic [EntW-1:0]       g_ent_q, g_ent_d;
`endif
  logic [EntW-1:0]       fifo_q [2];
  logic [EntW-1:0]       fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  ready_en_q, ready_en_d;

  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic [EntW-1:0]       lookup;
  logic                  last_valid;
  logic [EntW-1:0]       last_ent;
  logic                  out_valid;
  logic [EntW-1:0]       out_ent;
  logic                  accept, deq, pop, bypass, push, last_hold, wr_ptr;

  // Address range check and ROM lookup. The index is forced to 0 when the address is out of range.
  always_comb begin
    in_range = 32'(req_addr) < DEPTH;
    idx      = in_range ? req_addr[IdxW-1:0] : '0;
    lookup   = in_range ? {1'b0, mem[idx]} : {1'b1, {DATA_WIDTH{1'b0}}};
  end

`ifdef ROM_OUT_REG_EN
  assign last_valid = g_valid_q;
  assign last_ent   = g_ent_q;
`else
  assign last_valid = f_valid_q;
  assign last_ent   = f_ent_q;
`endif

  // Response outputs and request ready. These depend on registered state only.
  always_comb begin
    out_valid  = (cnt_q != 2'd0) || last_valid;
    out_ent    = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : last_ent;
    resp_valid = out_valid;
    resp_err   = out_valid & out_ent[DATA_WIDTH];
    resp_data  = out_valid ? out_ent[DATA_WIDTH-1:0] : '0;
    req_ready  = ready_en_q && (32'(occ_q) < Cap);
  end

  // Next-state logic for the handshakes, the pipeline stages, the FIFO and the occupancy count.
  always_comb begin
    accept    = req_valid && req_ready;
    deq       = out_valid && resp_ready;
    pop       = deq && (cnt_q != 2'd0);
    bypass    = deq && (cnt_q == 2'd0);
    // The last stage moves into the FIFO unless it is consumed directly this cycle.
    push      = last_valid && !bypass && ((cnt_q != 2'd2) || pop);
    // last_hold can only be set when occ is at CAP. No accept can happen in that cycle.
    last_hold = last_valid && !bypass && !push;
    wr_ptr    = rd_ptr_q ^ cnt_q[0];

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr] = last_ent;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};

    occ_d = occ_q;
    if (accept && !deq) occ_d = occ_q + 2'd1;
    else if (!accept && deq) occ_d = occ_q - 2'd1;

    ready_en_d = 1'b1;

`ifdef ROM_OUT_REG_EN
    g_valid_d = last_hold ? g_valid_q : f_valid_q;
    g_ent_d   = last_hold ? g_ent_q : f_ent_q;
    f_valid_d = accept || (last_hold && f_valid_q);
    f_ent_d   = accept ? lookup : f_ent_q;
`else
    f_valid_d = accept || last_hold;
    f_ent_d   = accept ? lookup : f_ent_q;
`endif
  end

  // State registers. A synchronous reset clears all in-flight state but leaves the ROM contents unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_valid_q  <= 1'b0;
      f_ent_q    <= '0;
`ifdef ROM_OUT_REG_EN
      g_valid_q  <= 1'b0;
      g_ent_q    <= '0;
`endif
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      occ_q      <= 2'd0;
      ready_en_q <= 1'b0;
    end else begin
      f_valid_q  <= f_valid_d;
      f_ent_q    <= f_ent_d;
`ifdef ROM_OUT_REG_EN
      g_valid_q  <= g_valid_d;
      g_ent_q    <= g_ent_d;
`endif
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_pipelined_rom.sv
// Self-checking bench for pipelined_rom. It uses directed steps, then random traffic.
// The reference model is a queue of expected responses tagged with their accept cycle.
module tb_pipelined_rom;

`ifdef ROM_OUT_REG_EN
  localparam int Lat = 2;
  localparam int Cap = 3;
`else
  localparam int Lat = 1;
  localparam int Cap = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  pipelined_rom dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] ent;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  bit          ready_en = 1'b0;
  bit          prev_rst = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_err;
  int          n_asserts = 0;
  int          n_fail = 0;

  // Words from the default table. Any address >= 64 gives an error response.
  function automatic logic [32:0] ref_word(input int a);
    if (a >= 64) return {1'b1, 32'h0};
    case (a)
      0:       return {1'b0, 32'h1};
      1, 2:    return {1'b0, 32'h11};
      3:       return {1'b0, 32'hF};
      4:       return {1'b0, 32'hC};
      5:       return {1'b0, 32'hD001};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Inputs are already driven. Check the outputs against the model,
  // record the handshakes, then advance to 1 time unit after the next rising edge.
  task automatic cycle();
    bit   exp_v;
    bit   rst_at_edge;
    exp_t e;
    #1;
    if (rst_n) begin
      check("req_ready", req_ready, (ready_en && q.size() < Cap));
      exp_v = (q.size() > 0) && (cyc >= q[0].t + Lat);
      check("resp_valid", resp_valid, exp_v);
      if (hold_prev) begin
        check("hold_data", resp_data, hold_data);
        check("hold_err", resp_err, hold_err);
      end
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) check("resp_spurious", resp_valid, 1'b0);
        else begin
          e = q.pop_front();
          check("resp_data", resp_data, e.ent[31:0]);
          check("resp_err", resp_err, e.ent[32]);
        end
      end
      hold_prev = resp_valid && !resp_ready;
      hold_data = resp_data;
      hold_err  = resp_err;
      if (req_valid && req_ready) q.push_back('{ent: ref_word(int'(req_addr)), t: cyc});
    end else if (prev_rst) begin
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_err", resp_err, 1'b0);
    end
    rst_at_edge = rst_n;
    @(posedge clk);
    cyc++;
    prev_rst = !rst_at_edge;
    if (!rst_at_edge) begin
      q.delete();
      ready_en  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      ready_en = 1'b1;
    end
    #1;
  endtask

  logic [7:0]  single_addr [3];
  logic [31:0] single_data [3];

  initial begin
    single_addr = '{8'd0, 8'd1, 8'd5};
    single_data = '{32'h1, 32'h11, 32'hD001};
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 8'd0; resp_ready = 1'b0;

    // Reset hold for 3 cycles, then release.
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    check("ready_after_release", req_ready, 1'b1);

    // Single reads at minimum latency.
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = single_addr[i];
      cycle();
      req_valid = 1'b0;
      repeat (Lat - 1) cycle();
      check("single_valid", resp_valid, 1'b1);
      check("single_data", resp_data, single_data[i]);
      check("single_err", resp_err, 1'b0);
      cycle();
    end

    // Back-to-back burst with no backpressure.
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_addr = 8'(i);
      cycle();
    end
    req_valid = 1'b0;
    repeat (Lat + 1) cycle();

    // Backpressure: ready drops at CAP and the head stays stable.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd3; cycle();
    req_addr = 8'd4; cycle();
    req_addr = 8'd2;
    repeat (3) cycle();
    check("bp_ready_low", req_ready, 1'b0);
    check("bp_head_data", resp_data, 32'hF);
    resp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    repeat (6) cycle();

    // Out-of-range addresses, followed by an in-range one.
    req_valid = 1'b1; req_addr = 8'd64; cycle();
    req_addr = 8'd255; cycle();
    req_addr = 8'd4; cycle();
    req_valid = 1'b0;
    repeat (Lat + 2) cycle();

    // Mid-operation reset with two requests in flight.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd1; cycle();
    req_addr = 8'd2; cycle();
    req_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; resp_ready = 1'b1;
    repeat (4) cycle();
    check("post_rst_no_resp", resp_valid, 1'b0);
    req_valid = 1'b1; req_addr = 8'd3; cycle();
    req_valid = 1'b0;
    repeat (Lat - 1) cycle();
    check("post_rst_valid", resp_valid, 1'b1);
    check("post_rst_data", resp_data, 32'hF);
    cycle();

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 79));
      resp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (6) cycle();
    check("drained", resp_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
